// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Bundle of the writeback stage's bus signals. It carries the
//                two ALU lane results, the long-latency valid/ready
//                handshake, and the two regfile write ports.
//                  slave  - the arbiter side (consumes results, drives regfile)
//                  master - the producer/observer side (execute units, bench)
//                Signals:
//                  wb1_*/wb2_*  lane 1 (older) / lane 2 (younger) results
//                  ll_*         long-latency result + ready + FIFO occupancy
//                  we_x, writeaddr_x, writedata_x  regfile port x
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wb1_valid;
   logic [4:0]    wb1_addr;
   logic [31:0]   wb1_data;
   logic          wb2_valid;
   logic [4:0]    wb2_addr;
   logic [31:0]   wb2_data;
   logic          ll_valid;
   logic          ll_ready;
   logic [4:0]    ll_addr;
   logic [31:0]   ll_data;
   logic          we_1;
   logic [4:0]    writeaddr_1;
   logic [31:0]   writedata_1;
   logic          we_2;
   logic [4:0]    writeaddr_2;
   logic [31:0]   writedata_2;
   logic [CW-1:0] ll_count;

   modport slave (
      input  wb1_valid, wb1_addr, wb1_data,
      input  wb2_valid, wb2_addr, wb2_data,
      input  ll_valid, ll_addr, ll_data,
      output ll_ready, ll_count,
      output we_1, writeaddr_1, writedata_1,
      output we_2, writeaddr_2, writedata_2
   );

   modport master (
      output wb1_valid, wb1_addr, wb1_data,
      output wb2_valid, wb2_addr, wb2_data,
      output ll_valid, ll_addr, ll_data,
      input  ll_ready, ll_count,
      input  we_1, writeaddr_1, writedata_1,
      input  we_2, writeaddr_2, writedata_2
   );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Dual-issue writeback arbiter. Merges ALU lane 1, ALU lane 2
//                and a queued long-latency source onto the two regfile write
//                ports. Lane results always win their own port; queued
//                results drain in order into whatever ports the lanes leave
//                free (up to two per cycle). All regfile outputs are
//                registered.
//  Ports       : clk  - clock
//                rst  - asynchronous, active-low reset
//                bus  - wb_arbiter_if.slave (lane inputs, long-latency
//                       handshake, regfile port outputs, FIFO occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  wire         clk,
   input  wire         rst,
   wb_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // FIFO storage and pointers
   logic [4:0]    mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   // head candidates
   logic [PW-1:0] rd_ptr1;
   logic [4:0]    h0_addr, h1_addr;
   logic [31:0]   h0_data, h1_data;

   // lane decisions
   logic e1, e2;

   // FIFO decisions
   logic push;
   logic h0_avail, h0_disc, h0_wr, h0_p1, h0_pop;
   logic h1_avail, h1_disc, h1_wr, h1_p1, h1_pop;
   logic free1_b, free2_b;
   logic kill_h0;
   logic [1:0] pops;

   // next-state of regfile ports
   logic        we1_n, we2_n;
   logic [4:0]  wa1_n, wa2_n;
   logic [31:0] wd1_n, wd2_n;

   // Ready comes from the registered count only, so a full FIFO refuses a
   // push even when it is popping in the same cycle.
   assign bus.ll_ready = (count < CW'(DEPTH));
   assign bus.ll_count = count;
   assign push         = bus.ll_valid & bus.ll_ready;

   assign rd_ptr1 = rd_ptr + PW'(1);
   assign h0_addr = mem_addr[rd_ptr];
   assign h0_data = mem_data[rd_ptr];
   assign h1_addr = mem_addr[rd_ptr1];
   assign h1_data = mem_data[rd_ptr1];

   always_comb begin
      // Lane 2 is younger and wins a same-register conflict; r0 writes vanish.
      e2 = bus.wb2_valid & (bus.wb2_addr != 5'd0);
      e1 = bus.wb1_valid & (bus.wb1_addr != 5'd0) &
           !(bus.wb2_valid & (bus.wb2_addr == bus.wb1_addr));

      // Head entry: a queued result is always older than a lane result to
      // the same register, so such a result is simply dropped.
      h0_avail = (count >= CW'(1));
      h0_disc  = (h0_addr == 5'd0) |
                 (e1 & (h0_addr == bus.wb1_addr)) |
                 (e2 & (h0_addr == bus.wb2_addr));
      h0_wr    = h0_avail & !h0_disc & (!e1 | !e2);
      h0_p1    = !e1;
      h0_pop   = h0_avail & (h0_disc | h0_wr);

      // Ports still free once the head has claimed one.
      free1_b = !e1 & !(h0_wr & h0_p1);
      free2_b = !e2 & !(h0_wr & !h0_p1);

      // Second entry is only considered if the head left the FIFO, which
      // keeps the drain strictly in order.
      h1_avail = (count >= CW'(2)) & h0_pop;
      h1_disc  = (h1_addr == 5'd0) |
                 (e1 & (h1_addr == bus.wb1_addr)) |
                 (e2 & (h1_addr == bus.wb2_addr));
      h1_wr    = h1_avail & !h1_disc & (free1_b | free2_b);
      h1_p1    = free1_b;
      h1_pop   = h1_avail & (h1_disc | h1_wr);

      // Two queued writes to the same register: the older one is dead. Port
      // allocation is done first, so the younger keeps the port it claimed.
      kill_h0 = h0_wr & h1_wr & (h0_addr == h1_addr);

      pops = {1'b0, h0_pop} + {1'b0, h1_pop};

      we1_n = 1'b0;
      wa1_n = bus.writeaddr_1;
      wd1_n = bus.writedata_1;
      if (e1) begin
         we1_n = 1'b1;
         wa1_n = bus.wb1_addr;
         wd1_n = bus.wb1_data;
      end else if (h0_wr & h0_p1 & !kill_h0) begin
         we1_n = 1'b1;
         wa1_n = h0_addr;
         wd1_n = h0_data;
      end else if (h1_wr & h1_p1) begin
         we1_n = 1'b1;
         wa1_n = h1_addr;
         wd1_n = h1_data;
      end

      we2_n = 1'b0;
      wa2_n = bus.writeaddr_2;
      wd2_n = bus.writedata_2;
      if (e2) begin
         we2_n = 1'b1;
         wa2_n = bus.wb2_addr;
         wd2_n = bus.wb2_data;
      end else if (h0_wr & !h0_p1 & !kill_h0) begin
         we2_n = 1'b1;
         wa2_n = h0_addr;
         wd2_n = h0_data;
      end else if (h1_wr & !h1_p1) begin
         we2_n = 1'b1;
         wa2_n = h1_addr;
         wd2_n = h1_data;
      end
   end

   // FIFO payload needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= bus.ll_addr;
         mem_data[wr_ptr] <= bus.ll_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
         bus.we_1        <= 1'b0;
         bus.writeaddr_1 <= '0;
         bus.writedata_1 <= '0;
         bus.we_2        <= 1'b0;
         bus.writeaddr_2 <= '0;
         bus.writedata_2 <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         rd_ptr          <= rd_ptr + PW'(pops);
         count           <= count + CW'(push) - CW'(pops);
         bus.we_1        <= we1_n;
         bus.writeaddr_1 <= wa1_n;
         bus.writedata_1 <= wd1_n;
         bus.we_2        <= we2_n;
         bus.writeaddr_2 <= wa2_n;
         bus.writedata_2 <= wd2_n;
      end
   end
endmodule
`default_nettype wire
